mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage.sv | 160 ++++++++++++++++
 tb/tb_mem_stage.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Memory stage: issues one data-memory access per instruction over a gnt/rvalid
// handshake and produces a registered single-cycle writeback pulse.
module mem_stage #(
    parameter int CTRL_WIDTH = 16,
    parameter int XLEN       = 32
) (
    input  logic                  clk_ip,
    input  logic                  rst_ip,
    input  logic                  valid_ip,
    input  logic [CTRL_WIDTH-1:0] ctrl_ip,
    input  logic [XLEN-1:0]       alu_result_ip,
    input  logic [XLEN-1:0]       rs2_data_ip,
    input  logic [2:0]            funct3_ip,
    input  logic [4:0]            rd_ip,
    output logic                  stall_op,
    output logic                  dmem_req_op,
    output logic                  dmem_we_op,
    output logic [XLEN-1:0]       dmem_addr_op,
    output logic [XLEN-1:0]       dmem_wdata_op,
    output logic [3:0]            dmem_be_op,
    input  logic                  dmem_gnt_ip,
    input  logic                  dmem_rvalid_ip,
    input  logic [XLEN-1:0]       dmem_rdata_ip,
    output logic                  wb_valid_op,
    output logic                  wb_reg_wr_en_op,
    output logic [4:0]            wb_rd_op,
    output logic [XLEN-1:0]       wb_data_op,
    output logic                  misalign_op
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]      state;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] rs2_q;
    logic [2:0]      funct3_q;
    logic [4:0]      rd_q;
    logic            wen_q;
    logic            we_q;

    logic            in_mem;
    logic            in_bad;
    logic            in_size_bad;
    logic [3:0]      be_base;
    logic [XLEN-1:0] wdata_rep;
    logic [XLEN-1:0] rd_shift;
    logic [XLEN-1:0] load_data;
    logic            unused_ctrl;

    // Branch/mem-to-reg flags and the upper control bits do not affect this stage.
    assign unused_ctrl = ^{ctrl_ip[CTRL_WIDTH-1:4], ctrl_ip[0]};

    assign in_mem      = ctrl_ip[3] | ctrl_ip[2];
    assign in_size_bad = funct3_ip[1] ? (alu_result_ip[1:0] != 2'b00)
                       : (funct3_ip[0] & alu_result_ip[0]);
    assign in_bad      = in_mem & ((ctrl_ip[3] & ctrl_ip[2]) | in_size_bad);

    always_comb begin
        be_base   = 4'b0001;
        wdata_rep = {(XLEN/8){rs2_q[7:0]}};
        if (funct3_q[1]) begin
            be_base   = 4'b1111;
            wdata_rep = rs2_q;
        end else if (funct3_q[0]) begin
            be_base   = 4'b0011;
            wdata_rep = {(XLEN/16){rs2_q[15:0]}};
        end
    end

    always_comb begin
        rd_shift  = dmem_rdata_ip >> {addr_q[1:0], 3'b000};
        load_data = dmem_rdata_ip;
        if (!funct3_q[1]) begin
            if (funct3_q[0]) begin
                load_data = {{(XLEN-16){rd_shift[15] & ~funct3_q[2]}}, rd_shift[15:0]};
            end else begin
                load_data = {{(XLEN-8){rd_shift[7] & ~funct3_q[2]}}, rd_shift[7:0]};
            end
        end
    end

    assign stall_op      = (state != IDLE);
    assign dmem_req_op   = (state == REQ);
    assign dmem_we_op    = dmem_req_op & we_q;
    assign dmem_addr_op  = dmem_req_op ? {addr_q[XLEN-1:2], 2'b00} : '0;
    assign dmem_wdata_op = dmem_req_op ? wdata_rep : '0;
    assign dmem_be_op    = dmem_req_op ? (be_base << addr_q[1:0]) : 4'b0000;

    always_ff @(posedge clk_ip or posedge rst_ip) begin
        if (rst_ip) begin
            state           <= IDLE;
            addr_q          <= '0;
            rs2_q           <= '0;
            funct3_q        <= '0;
            rd_q            <= '0;
            wen_q           <= 1'b0;
            we_q            <= 1'b0;
            wb_valid_op     <= 1'b0;
            wb_reg_wr_en_op <= 1'b0;
            wb_rd_op        <= '0;
            wb_data_op      <= '0;
            misalign_op     <= 1'b0;
        end else begin
            wb_valid_op <= 1'b0;
            misalign_op <= 1'b0;
            case (state)
                IDLE: begin
                    if (valid_ip) begin
                        addr_q   <= alu_result_ip;
                        rs2_q    <= rs2_data_ip;
                        funct3_q <= funct3_ip;
                        rd_q     <= rd_ip;
                        wen_q    <= ctrl_ip[1];
                        we_q     <= ctrl_ip[2];
                        if (in_bad) begin
                            misalign_op     <= 1'b1;
                            wb_valid_op     <= 1'b1;
                            wb_reg_wr_en_op <= 1'b0;
                            wb_rd_op        <= rd_ip;
                            wb_data_op      <= alu_result_ip;
                        end else if (in_mem) begin
                            state <= REQ;
                        end else begin
                            wb_valid_op     <= 1'b1;
                            wb_reg_wr_en_op <= ctrl_ip[1];
                            wb_rd_op        <= rd_ip;
                            wb_data_op      <= alu_result_ip;
                        end
                    end
                end
                REQ: begin
                    if (dmem_gnt_ip) begin
                        if (we_q) begin
                            state           <= IDLE;
                            wb_valid_op     <= 1'b1;
                            wb_reg_wr_en_op <= 1'b0;
                            wb_rd_op        <= rd_q;
                            wb_data_op      <= addr_q;
                        end else begin
                            state <= RESP;
                        end
                    end
                end
                RESP: begin
                    if (dmem_rvalid_ip) begin
                        state           <= IDLE;
                        wb_valid_op     <= 1'b1;
                        wb_reg_wr_en_op <= wen_q;
                        wb_rd_op        <= rd_q;
                        wb_data_op      <= load_data;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed-vector bench for mem_stage: ALU, store, load, misalign,
// reset abandonment and back-to-back sequencing.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic [15:0] ctrl;
    logic [31:0] alu;
    logic [31:0] rs2;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic        stall;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        wb_valid;
    logic        wb_reg_wr_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        misalign;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_stage #(.CTRL_WIDTH(16), .XLEN(32)) dut (
        .clk_ip         (clk),
        .rst_ip         (rst),
        .valid_ip       (valid),
        .ctrl_ip        (ctrl),
        .alu_result_ip  (alu),
        .rs2_data_ip    (rs2),
        .funct3_ip      (funct3),
        .rd_ip          (rd),
        .stall_op       (stall),
        .dmem_req_op    (dmem_req),
        .dmem_we_op     (dmem_we),
        .dmem_addr_op   (dmem_addr),
        .dmem_wdata_op  (dmem_wdata),
        .dmem_be_op     (dmem_be),
        .dmem_gnt_ip    (dmem_gnt),
        .dmem_rvalid_ip (dmem_rvalid),
        .dmem_rdata_ip  (dmem_rdata),
        .wb_valid_op    (wb_valid),
        .wb_reg_wr_en_op(wb_reg_wr_en),
        .wb_rd_op       (wb_rd),
        .wb_data_op     (wb_data),
        .misalign_op    (misalign)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [15:0] c, input logic [31:0] a,
                           input logic [31:0] d, input logic [2:0] f,
                           input logic [4:0] r);
        valid  = 1'b1;
        ctrl   = c;
        alu    = a;
        rs2    = d;
        funct3 = f;
        rd     = r;
    endtask

    task automatic wb_expect(input string tag, input logic [31:0] data,
                             input logic wen, input logic [4:0] r);
        check({tag, "_wbv"}, {31'd0, wb_valid}, 32'd1);
        check({tag, "_data"}, wb_data, data);
        check({tag, "_wen"}, {31'd0, wb_reg_wr_en}, {31'd0, wen});
        check({tag, "_rd"}, {27'd0, wb_rd}, {27'd0, r});
    endtask

    // Runs a load through REQ (gnt after gnt_delay cycles) and RESP.
    task automatic do_load(input string tag, input logic [31:0] a,
                           input logic [2:0] f, input logic [31:0] rdata,
                           input logic [31:0] exp, input int gnt_delay);
        present(16'h000B, a, 32'h0, f, 5'd7);
        step();
        valid = 1'b0;
        check({tag, "_req"}, {31'd0, dmem_req}, 32'd1);
        check({tag, "_we"}, {31'd0, dmem_we}, 32'd0);
        check({tag, "_addr"}, dmem_addr, {a[31:2], 2'b00});
        for (int i = 0; i < gnt_delay; i++) begin
            step();
            check({tag, "_hold"}, {30'd0, stall, dmem_req}, 32'd3);
        end
        dmem_gnt    = 1'b1;
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h5A5A5A5A;
        step();
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b0;
        check({tag, "_resp"}, {30'd0, stall, dmem_req}, 32'd2);
        check({tag, "_early"}, {31'd0, wb_valid}, 32'd0);
        step();
        check({tag, "_wait"}, {30'd0, stall, wb_valid}, 32'd2);
        dmem_rvalid = 1'b1;
        dmem_rdata  = rdata;
        step();
        dmem_rvalid = 1'b0;
        wb_expect(tag, exp, 1'b1, 5'd7);
        check({tag, "_idle"}, {31'd0, stall}, 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        valid = 1'b0;
        ctrl = '0;
        alu = '0;
        rs2 = '0;
        funct3 = '0;
        rd = '0;
        dmem_gnt = 1'b0;
        dmem_rvalid = 1'b0;
        dmem_rdata = '0;
        step();
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_req", {30'd0, dmem_req, dmem_we}, 32'd0);
        check("rst_wb", {30'd0, wb_valid, misalign}, 32'd0);
        check("rst_data", wb_data, 32'd0);
        check("rst_be", {28'd0, dmem_be}, 32'd0);
        rst = 1'b0;
        step();

        // ALU op
        present(16'h0002, 32'h1234, 32'h0, 3'b010, 5'd5);
        step();
        valid = 1'b0;
        wb_expect("alu", 32'h1234, 1'b1, 5'd5);
        check("alu_req", {30'd0, stall, dmem_req}, 32'd0);
        step();
        check("alu_pulse", {31'd0, wb_valid}, 32'd0);
        check("alu_keep", wb_data, 32'h1234);

        // SB with gnt already high
        present(16'h0004, 32'h103, 32'hAB, 3'b000, 5'd1);
        dmem_gnt = 1'b1;
        step();
        valid = 1'b0;
        check("sb_req", {29'd0, stall, dmem_req, dmem_we}, 32'd7);
        check("sb_addr", dmem_addr, 32'h100);
        check("sb_be", {28'd0, dmem_be}, 32'h8);
        check("sb_wdata", dmem_wdata, 32'hABABABAB);
        check("sb_nowb", {31'd0, wb_valid}, 32'd0);
        step();
        dmem_gnt = 1'b0;
        check("sb_wbv", {31'd0, wb_valid}, 32'd1);
        check("sb_wen", {31'd0, wb_reg_wr_en}, 32'd0);
        check("sb_idle", {30'd0, stall, dmem_req}, 32'd0);

        // SH upper half
        present(16'h0004, 32'h102, 32'h1234CDEF, 3'b001, 5'd2);
        step();
        valid = 1'b0;
        check("sh_be", {28'd0, dmem_be}, 32'hC);
        check("sh_wdata", dmem_wdata, 32'hCDEFCDEF);
        step();
        check("sh_stall", {31'd0, stall}, 32'd1);
        dmem_gnt = 1'b1;
        step();
        dmem_gnt = 1'b0;
        check("sh_wbv", {30'd0, wb_valid, stall}, 32'd2);

        // Loads: sign/zero extension, halfword, word
        do_load("lb", 32'h202, 3'b000, 32'h00800000, 32'hFFFFFF80, 2);
        do_load("lbu", 32'h202, 3'b100, 32'h00800000, 32'h00000080, 2);
        do_load("lh", 32'h102, 3'b001, 32'h80010000, 32'hFFFF8001, 0);
        do_load("lhu", 32'h102, 3'b101, 32'h80010000, 32'h00008001, 1);
        do_load("lw", 32'h300, 3'b010, 32'hDEADBEEF, 32'hDEADBEEF, 0);

        // Misaligned LW
        present(16'h000A, 32'h6, 32'h0, 3'b010, 5'd9);
        step();
        valid = 1'b0;
        check("mis_pulse", {31'd0, misalign}, 32'd1);
        check("mis_req", {30'd0, stall, dmem_req}, 32'd0);
        check("mis_wb", {30'd0, wb_valid, wb_reg_wr_en}, 32'd2);
        step();
        check("mis_end", {30'd0, misalign, wb_valid}, 32'd0);

        // Load+store both set is rejected
        present(16'h000E, 32'h40, 32'h0, 3'b010, 5'd9);
        step();
        valid = 1'b0;
        check("both_mis", {30'd0, misalign, stall}, 32'd2);
        step();

        // Reset during RESP, late rvalid ignored
        present(16'h000B, 32'h400, 32'h0, 3'b010, 5'd6);
        step();
        valid = 1'b0;
        dmem_gnt = 1'b1;
        step();
        dmem_gnt = 1'b0;
        check("rr_resp", {31'd0, stall}, 32'd1);
        rst = 1'b1;
        #1;
        check("rr_async", {29'd0, stall, dmem_req, wb_valid}, 32'd0);
        step();
        rst = 1'b0;
        dmem_rvalid = 1'b1;
        dmem_rdata = 32'h12345678;
        step();
        dmem_rvalid = 1'b0;
        check("rr_late", {29'd0, stall, dmem_req, wb_valid}, 32'd0);
        check("rr_data", wb_data, 32'd0);

        // Load then ALU op held during stall
        present(16'h000B, 32'h500, 32'h0, 3'b010, 5'd3);
        step();
        present(16'h0002, 32'h77, 32'h0, 3'b010, 5'd4);
        dmem_gnt = 1'b1;
        step();
        dmem_gnt = 1'b0;
        check("b2b_hold", {30'd0, stall, wb_valid}, 32'd2);
        dmem_rvalid = 1'b1;
        dmem_rdata = 32'h11223344;
        step();
        dmem_rvalid = 1'b0;
        wb_expect("b2b_ld", 32'h11223344, 1'b1, 5'd3);
        step();
        valid = 1'b0;
        wb_expect("b2b_alu", 32'h77, 1'b1, 5'd4);
        step();
        check("b2b_end", {30'd0, wb_valid, stall}, 32'd0);
        check("b2b_keep", {27'd0, wb_rd}, 32'd4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
